// File: rtl/isqrt_pkg.sv
// Shared definitions for the sequential integer square-root extractor:
// FSM encoding and a constant-width helper.
package isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } isqrt_state_t;

  // Number of bits needed to count up to v-1; evaluated at elaboration only.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational:
// brings in the next two radicand bits and decides one root bit.
module isqrt_step #(
  parameter int HW = 4,
  parameter int RW = HW + 2
) (
  input  logic [RW-1:0] rem_acc,
  input  logic [HW-1:0] root_acc,
  input  logic [1:0]    op_bits,
  output logic [RW-1:0] rem_next,
  output logic [HW-1:0] root_next
);

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic [HW-1:0] root_sh;
  logic          ge;

  // rem_acc never exceeds 2*root_acc, so the 2-bit shift cannot lose bits.
  assign rem_sh    = (rem_acc << 2) | RW'(op_bits);
  assign trial     = {root_acc, 2'b01};
  assign ge        = (rem_sh >= trial);
  assign root_sh   = root_acc << 1;
  assign rem_next  = ge ? (rem_sh - trial) : rem_sh;
  assign root_next = root_sh | HW'(ge);

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: one root bit per clock, start/busy/done
// handshake. root/rem hold the last result while idle or done.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int CW = clog2(HW + 1);

  // Handshake: start is accepted on an edge where the FSM sits in IDLE or
  // DONE; busy covers the iteration cycles, done pulses once when root/rem
  // become valid, and the two are never high together.
  isqrt_state_t state, state_next;

  logic [WIDTH-1:0] op;
  logic [RW-1:0]    rem_acc;
  logic [HW-1:0]    root_acc;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rem_step;
  logic [HW-1:0]    root_step;
  logic             load;
  logic             iter;

  isqrt_step #(
    .HW (HW),
    .RW (RW)
  ) u_step (
    .rem_acc   (rem_acc),
    .root_acc  (root_acc),
    .op_bits   (op[WIDTH-1:WIDTH-2]),
    .rem_next  (rem_step),
    .root_next (root_step)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    iter       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        iter = 1'b1;
        // cnt==1 means this edge performs the final iteration.
        if (cnt == CW'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_CALC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op       <= '0;
      rem_acc  <= '0;
      root_acc <= '0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        op       <= radicand;
        rem_acc  <= '0;
        root_acc <= '0;
        cnt      <= CW'(HW);
      end else if (iter) begin
        op       <= op << 2;
        rem_acc  <= rem_step;
        root_acc <= root_step;
        cnt      <= cnt - CW'(1);
      end
    end
  end

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);
  assign root = root_acc;
  assign rem  = rem_acc[HW:0];

endmodule
